lsu_mem_stage: RTL and testbench

Memory stage of the RISC-V pipeline. It sits directly downstream of the EX-stage ALU and consumes the ALU result as either a writeback value or a load/store byte address. The block performs byte, halfword and word loads and stores over a request/response data-memory port, stalling EX while an access is in flight. It presents one registered writeback record per accepted instruction.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu_mem_stage.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store memory stage.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP
  } lsu_state_e;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the memory stage: store shift, strobes,
// misalignment detection and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic [31:0] load_val
);

  logic [4:0]  shamt;
  logic [31:0] rshift;
  logic        is_unsigned;

  always_comb begin
    shamt       = {off, 3'b000};
    wdata       = store_data << shamt;
    rshift      = rdata >> shamt;
    is_unsigned = (funct3 == F3_BU) || (funct3 == F3_HU);
    wstrb       = STRB_W;
    misaligned  = 1'b0;
    load_val    = rshift;
    case (funct3)
      F3_B, F3_BU: begin
        wstrb    = STRB_B << off;
        load_val = is_unsigned ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      end
      F3_H, F3_HU: begin
        wstrb      = STRB_H << off;
        misaligned = off[0];
        load_val   = is_unsigned ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      end
      // F3_W and every undefined encoding behave as a word access
      default: begin
        wstrb      = STRB_W;
        misaligned = (off != 2'b00);
        load_val   = rshift;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RISC-V memory stage: ALU pass-through, aligned loads/stores over a
// request/response data port, one registered writeback record per instruction.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] alu_res,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rd,
  input  logic                  reg_write,
  input  logic                  flush,
  output logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic                  wb_reg_write,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  lsu_misaligned
);

  lsu_state_e state, state_next;

  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        regw_q;
  logic        accept, is_mem, is_store;
  logic [1:0]  al_off;
  logic [2:0]  al_f3;
  logic [31:0] al_wdata, al_load;
  logic [3:0]  al_wstrb;
  logic        al_mis;

  assign ex_ready = rst_n && (state == S_IDLE);
  assign accept   = ex_valid && ex_ready && !flush;
  // Both op bits set is illegal and falls through as ALU-only
  assign is_mem   = mem_read ^ mem_write;
  assign is_store = mem_write && !mem_read;

  // In IDLE the lanes follow the offered op; afterwards the latched access
  assign al_off = (state == S_IDLE) ? alu_res[1:0] : dmem_addr[1:0];
  assign al_f3  = (state == S_IDLE) ? funct3 : f3_q;

  lsu_align u_align (
    .off        (al_off),
    .funct3     (al_f3),
    .store_data (32'(store_data)),
    .rdata      (dmem_rdata),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .misaligned (al_mis),
    .load_val   (al_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && is_mem && !al_mis) state_next = S_REQ;
      S_REQ:   if (dmem_ready) state_next = dmem_we ? S_IDLE : S_RSP;
      S_RSP:   if (dmem_rvalid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
      wb_data        <= '0;
      lsu_misaligned <= 1'b0;
      f3_q           <= '0;
      rd_q           <= '0;
      regw_q         <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      lsu_misaligned <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= alu_res;
              wb_rd        <= rd;
              wb_reg_write <= reg_write;
            end else if (al_mis) begin
              wb_valid       <= 1'b1;
              wb_data        <= '0;
              wb_rd          <= rd;
              wb_reg_write   <= 1'b0;
              lsu_misaligned <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= ADDR_WIDTH'(alu_res);
              dmem_wdata <= is_store ? al_wdata : '0;
              dmem_wstrb <= is_store ? al_wstrb : 4'b0000;
              f3_q       <= funct3;
              rd_q       <= rd;
              regw_q     <= reg_write;
            end
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              wb_valid     <= 1'b1;
              wb_data      <= '0;
              wb_rd        <= rd_q;
              wb_reg_write <= 1'b0;
            end
          end
        end
        S_RSP: begin
          if (dmem_rvalid) begin
            wb_valid     <= 1'b1;
            wb_data      <= DATA_WIDTH'(al_load);
            wb_rd        <= rd_q;
            wb_reg_write <= regw_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed scenarios plus random traffic
// against a byte-lane reference model and a randomly delayed memory responder.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_res, store_data;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write, flush;
  logic        dmem_req, dmem_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_reg_write, lsu_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        rsp_ready, rsp_rvalid, stray_rvalid;
  logic [31:0] rsp_rdata, stray_rdata;

  assign dmem_ready  = rsp_ready;
  assign dmem_rvalid = rsp_rvalid | stray_rvalid;
  assign dmem_rdata  = stray_rvalid ? stray_rdata : rsp_rdata;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_res(alu_res), .store_data(store_data), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .rd(rd), .reg_write(reg_write),
    .flush(flush), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .lsu_misaligned(lsu_misaligned)
  );

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    bit          mis;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gd;
    int          rvd;
    logic [31:0] rdata;
    bit          hang;
  } req_t;

  wb_t  wbq[$];
  req_t reqq[$];
  int   cycq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_req(input req_t r);
    chk("dmem_req_held", 32'(dmem_req), 32'd1);
    chk("dmem_we", 32'(dmem_we), 32'(r.we));
    chk("dmem_addr", dmem_addr, r.addr);
    chk("dmem_wstrb", 32'(dmem_wstrb), 32'(r.wstrb));
    if (r.we) chk("dmem_wdata", dmem_wdata, r.wdata);
  endtask

  // Reference model: decide what the instruction must produce, then offer it
  task automatic send(input logic mr, input logic mw, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                      input logic rw, input logic fl, input int gd, input int rvd,
                      input logic [31:0] rdat, input bit hang);
    wb_t         w;
    req_t        q;
    int          n, s, waited;
    bit          uns, mem, direct;
    logic [31:0] mask, field;
    mem    = mr ^ mw;
    direct = 1'b0;
    case (f3)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      default:        n = 4;
    endcase
    uns = (f3 == 3'b100) || (f3 == 3'b101);
    s   = int'(a % 4);
    if (!fl) begin
      if (!mem) begin
        w.chk_data = 1; w.data = a; w.rd = r; w.rw = rw; w.mis = 0;
        wbq.push_back(w);
        direct = 1'b1;
      end else if ((a % n) != 0) begin
        w.chk_data = 0; w.data = 0; w.rd = r; w.rw = 0; w.mis = 1;
        wbq.push_back(w);
        direct = 1'b1;
      end else begin
        q.we    = mw;
        q.addr  = a;
        q.wdata = sd << (8 * s);
        q.wstrb = mw ? 4'(((1 << n) - 1) << s) : 4'b0000;
        q.gd    = gd;
        q.rvd   = rvd;
        q.rdata = rdat;
        q.hang  = hang;
        reqq.push_back(q);
        if (mw) begin
          w.chk_data = 0; w.data = 0; w.rd = r; w.rw = 0; w.mis = 0;
          wbq.push_back(w);
        end else if (!hang) begin
          mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
          field = (rdat >> (8 * s)) & mask;
          if (!uns && n < 4 && field[8 * n - 1]) field = field | ~mask;
          w.chk_data = 1; w.data = field; w.rd = r; w.rw = rw; w.mis = 0;
          wbq.push_back(w);
        end
      end
    end
    ex_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f3;
    alu_res = a; store_data = sd; rd = r; reg_write = rw; flush = fl;
    waited = 0;
    while (!ex_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ex_ready) begin
      $display("FAIL ex_ready_timeout: got 0 expected 1 after %0d cycles", waited);
      $fatal(1, "ex_ready never returned");
    end
    @(posedge clk); #1;
    if (direct) cycq.push_back(cyc);
    ex_valid = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_res = $urandom; store_data = $urandom;
  endtask

  // Memory responder: grants after the requested delay, then returns load data
  initial begin
    req_t r;
    rsp_ready = 1'b0; rsp_rvalid = 1'b0; rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && dmem_req) begin
        if (reqq.size() == 0) begin
          chk("dmem_req_unexpected", 32'(dmem_req), 32'd0);
          rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
        end else begin
          r = reqq.pop_front();
          for (int i = 0; i < r.gd; i++) begin
            chk_req(r);
            @(negedge clk);
          end
          chk_req(r);
          rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
          if (r.we) cycq.push_back(cyc);
          else if (!r.hang) begin
            for (int i = 0; i < r.rvd; i++) begin
              rsp_rdata = $urandom;
              @(posedge clk); #1;
            end
            rsp_rvalid = 1'b1; rsp_rdata = r.rdata;
            @(posedge clk); #1;
            cycq.push_back(cyc);
            rsp_rvalid = 1'b0; rsp_rdata = $urandom;
          end
        end
      end
    end
  end

  // Writeback monitor
  always @(negedge clk) begin
    wb_t e;
    int  c;
    if (rst_n) begin
      if (wb_valid) begin
        if (wbq.size() == 0) begin
          chk("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          e = wbq.pop_front();
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          chk("lsu_misaligned", 32'(lsu_misaligned), 32'(e.mis));
          if (e.chk_data) begin
            chk("wb_data", wb_data, e.data);
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          end
          if (cycq.size() == 0) chk("wb_timing_missing", 32'(wb_valid), 32'd0);
          else begin
            c = cycq.pop_front();
            chk("wb_cycle", 32'(cyc), 32'(c));
          end
        end
      end else if (lsu_misaligned) begin
        chk("mis_without_wb", 32'(lsu_misaligned), 32'd0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ex_ready"}, 32'(ex_ready), 32'd0);
    chk({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_dmem_wstrb"}, 32'(dmem_wstrb), 32'd0);
    chk({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_lsu_misaligned"}, 32'(lsu_misaligned), 32'd0);
  endtask

  initial begin
    logic        mr, mw, fl, rw;
    logic [2:0]  f3;
    logic [4:0]  r;
    int          k;
    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b0; alu_res = 32'h0; store_data = 32'h0; rd = 5'h0; reg_write = 1'b0;
    stray_rvalid = 1'b0; stray_rdata = 32'h0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ex_ready_after_reset", 32'(ex_ready), 32'd1);

    // ALU-only burst, consecutive writebacks, no bus traffic
    send(0, 0, 3'b000, 32'd5, 32'h0, 5'd1, 1, 0, 0, 0, 0, 0);
    send(0, 0, 3'b000, 32'd6, 32'h0, 5'd2, 1, 0, 0, 0, 0, 0);
    send(0, 0, 3'b000, 32'd7, 32'h0, 5'd3, 1, 0, 0, 0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end

    // SB at 0x1003 with a three-cycle grant delay
    send(0, 1, 3'b000, 32'h1003, 32'h0000_00AB, 5'd4, 1, 0, 3, 0, 0, 0);
    // LB / LBU at 0x2001, rvalid two cycles after grant
    send(1, 0, 3'b000, 32'h2001, 32'h0, 5'd5, 1, 0, 0, 1, 32'h0000_8000, 0);
    send(1, 0, 3'b100, 32'h2001, 32'h0, 5'd6, 1, 0, 0, 1, 32'h0000_8000, 0);
    // Misaligned LW
    send(1, 0, 3'b010, 32'h3002, 32'h0, 5'd7, 1, 0, 0, 0, 0, 0);
    // Flushed SW: nothing may come out
    send(0, 1, 3'b010, 32'h4000, 32'h1234_5678, 5'd8, 1, 1, 0, 0, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush_no_req", 32'(dmem_req), 32'd0);
    end

    // Reset while the load waits for its response
    send(1, 0, 3'b010, 32'h5000, 32'h0, 5'd9, 1, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    stray_rvalid = 1'b1; stray_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    stray_rvalid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray_ex_ready", 32'(ex_ready), 32'd1);
      chk("stray_no_req", 32'(dmem_req), 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      k  = $urandom_range(0, 9);
      mr = (k < 4) || (k == 9);
      mw = ((k >= 4) && (k < 7)) || (k == 9);
      f3 = 3'($urandom_range(0, 7));
      r  = 5'($urandom);
      rw = 1'($urandom);
      fl = ($urandom_range(0, 9) == 0);
      send(mr, mw, f3, $urandom, $urandom, r, rw, fl,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    k = 0;
    while ((wbq.size() != 0 || reqq.size() != 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("wb_queue_drained", 32'(wbq.size()), 32'd0);
    chk("req_queue_drained", 32'(reqq.size()), 32'd0);
    chk("cycle_queue_drained", 32'(cycq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
